// File: rtl/d_cache_pkg.sv
// Core-wide micro-op definitions shared by the decoder, the load/store stage
// and the data cache.
package d_cache_pkg;

    localparam int UOP_W = 5;

    localparam logic [UOP_W-1:0] STR_UOP  = 5'b01001;
    localparam logic [UOP_W-1:0] LDR_UOP  = 5'b01010;
    localparam logic [UOP_W-1:0] STRB_UOP = 5'b01011;
    localparam logic [UOP_W-1:0] LDRB_UOP = 5'b01100;

endpackage

// File: rtl/d_cache_ram.sv
// Word array for the data cache. Combinational read at the current index,
// byte-lane-masked synchronous write and a single-cycle synchronous clear.
module d_cache_ram #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_W    = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [ADDR_BITS-1:0]  index,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every word at once, otherwise write the enabled lanes of one word.
    always_ff @(posedge clock) begin
        if (clear) begin
            // NOTE: the whole array is cleared in one edge; this forces a
            // register-based array rather than an inferred block RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int l = 0; l < LANES; l++) begin
                if (byte_en[l]) begin
                    mem[index][8*l +: 8] <= wdata[8*l +: 8];
                end
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/d_cache.sv
// Data cache for the load/store stage: decodes the micro-op, drives the word
// array and registers the load/store-forward result on data_out.
// Optional build macro: DCACHE_BYTE_EN adds the STRB/LDRB byte micro-ops.
module d_cache
    import d_cache_pkg::*;
#(
    parameter int ADDR_BITS = 5,
    parameter int DATA_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [UOP_W-1:0]  uop,
    output logic [DATA_W-1:0] data_out
);

    localparam int LANES = DATA_W / 8;

    logic [ADDR_BITS-1:0] index;
    logic                 we;
    logic [LANES-1:0]     byte_en;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    rdata;
    logic [DATA_W-1:0]    next_out;
    logic                 load_out;

    // Upper address bits only alias; they carry no information here.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_BITS];

`ifdef DCACHE_BYTE_EN
    logic              is_byte;
    logic [1:0]        lane;
    logic [7:0]        rd_byte;
    logic [DATA_W-1:0] merged;

    assign is_byte = (uop == STRB_UOP) || (uop == LDRB_UOP);
    assign lane    = addr[1:0];
    assign index   = is_byte ? addr[ADDR_BITS+1:2] : addr[ADDR_BITS-1:0];

    // Extract the addressed byte and build the word a byte store will leave.
    always_comb begin
        rd_byte = rdata[{lane, 3'b000} +: 8];
        merged  = rdata;
        for (int i = 0; i < LANES; i++) begin
            if (i == int'(lane)) begin
                merged[8*i +: 8] = data_in[7:0];
            end
        end
    end
`else
    assign index = addr[ADDR_BITS-1:0];
`endif

    // Decode the micro-op into array write controls and the next output word.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // signal unassigned, which would infer a latch.
        we       = 1'b0;
        byte_en  = '1;
        wdata    = data_in;
        next_out = data_out;
        load_out = 1'b0;
        case (uop)
            STR_UOP: begin
                we       = 1'b1;
                next_out = data_in;
                load_out = 1'b1;
            end
            LDR_UOP: begin
                next_out = rdata;
                load_out = 1'b1;
            end
`ifdef DCACHE_BYTE_EN
            STRB_UOP: begin
                we          = 1'b1;
                byte_en     = '0;
                byte_en[lane] = 1'b1;
                wdata       = {LANES{data_in[7:0]}};
                next_out    = merged;
                load_out    = 1'b1;
            end
            LDRB_UOP: begin
                next_out = {{(DATA_W-8){1'b0}}, rd_byte};
                load_out = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    d_cache_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clock   (clock),
        .clear   (reset),
        .we      (we),
        .byte_en (byte_en),
        .index   (index),
        .wdata   (wdata),
        .rdata   (rdata)
    );

    // Output register: cleared by reset, updated only by load/store micro-ops.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignment so every register samples
        // pre-edge values regardless of process ordering.
        if (reset) begin
            data_out <= '0;
        end else if (load_out) begin
            data_out <= next_out;
        end
    end

endmodule

// File: tb/tb_d_cache.sv
// Self-checking bench for d_cache: directed test-plan steps followed by
// randomized traffic, all compared against an array-based reference model.
module tb_d_cache;

    localparam int ADDR_BITS = 5;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 32;

    localparam logic [4:0] U_STR  = 5'b01001;
    localparam logic [4:0] U_LDR  = 5'b01010;
    localparam logic [4:0] U_STRB = 5'b01011;
    localparam logic [4:0] U_LDRB = 5'b01100;
    localparam logic [4:0] U_NOP  = 5'b00000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [4:0]  uop = U_NOP;
    logic [31:0] data_out;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_out;

    d_cache #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (DATA_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .data_in  (data_in),
        .uop      (uop),
        .data_out (data_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one rising edge, straight from the uop rules.
    task automatic model_apply(input logic r, input logic [4:0] u, input logic [31:0] a,
                               input logic [31:0] d);
        int          w;
        int          ln;
        logic [31:0] word;
        w  = int'(a % DEPTH);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
            model_out = 32'h0;
            return;
        end
        if (u == U_STR) begin
            model_mem[w] = d;
            model_out    = d;
        end else if (u == U_LDR) begin
            model_out = model_mem[w];
        end
`ifdef DCACHE_BYTE_EN
        else if (u == U_STRB || u == U_LDRB) begin
            w    = int'((a >> 2) % DEPTH);
            ln   = int'(a % 4);
            word = model_mem[w];
            if (u == U_STRB) begin
                word[8*ln +: 8] = d[7:0];
                model_mem[w]    = word;
                model_out       = word;
            end else begin
                model_out = {24'h0, word[8*ln +: 8]};
            end
        end
`else
        ln   = 0;
        word = 32'h0;
        if (ln != 0 || word != 0) model_out = 32'hx;
`endif
    endtask

    // Drive one cycle away from the edge, update the model, settle, return.
    task automatic step(input logic r, input logic [4:0] u, input logic [31:0] a,
                        input logic [31:0] d);
        @(negedge clock);
        reset   = r;
        uop     = u;
        addr    = a;
        data_in = d;
        @(posedge clock);
        model_apply(r, u, a, d);
        #1;
    endtask

    task automatic step_check(input string tag, input logic r, input logic [4:0] u,
                              input logic [31:0] a, input logic [31:0] d);
        step(r, u, a, d);
        check(tag, data_out, model_out);
    endtask

    initial begin
        logic [4:0]  ru;
        logic [31:0] ra;
        logic [31:0] rd;
        logic        rr;
        int          sel;

        model_out = 32'h0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        // Reset for two cycles with a no-op pending on the inputs.
        step(1'b1, 5'b00010, 32'd31, 32'hDEADBEEF);
        step(1'b1, 5'b00010, 32'd31, 32'hDEADBEEF);
        check("reset_out", data_out, 32'h0);
        step_check("after_reset_nop", 1'b0, 5'b00010, 32'd31, 32'hDEADBEEF);
        step(1'b0, U_LDR, 32'd31, 32'h0);
        check("reset_mem31", data_out, 32'h0);

        // Store then load.
        step(1'b0, U_STR, 32'd10, 32'h12345678);
        check("str10_fwd", data_out, 32'h12345678);
        step(1'b0, U_LDR, 32'd10, 32'h0);
        check("ldr10", data_out, 32'h12345678);

        // Second location, no cross-corruption.
        step(1'b0, U_STR, 32'd5, 32'hAABBCCDD);
        check("str5_fwd", data_out, 32'hAABBCCDD);
        step(1'b0, U_LDR, 32'd5, 32'h0);
        check("ldr5", data_out, 32'hAABBCCDD);
        step(1'b0, U_LDR, 32'd10, 32'h0);
        check("ldr10_again", data_out, 32'h12345678);
        step(1'b0, U_LDR, 32'd5, 32'h0);

        // No-op hold across varying inputs.
        step(1'b0, U_NOP, 32'd5, 32'h01010101);
        check("nop_hold0", data_out, 32'hAABBCCDD);
        step(1'b0, U_NOP, 32'd10, 32'h02020202);
        check("nop_hold1", data_out, 32'hAABBCCDD);
        step(1'b0, U_NOP, 32'd7, 32'h03030303);
        check("nop_hold2", data_out, 32'hAABBCCDD);
        step(1'b0, U_LDR, 32'd5, 32'h0);
        check("nop_ldr5", data_out, 32'hAABBCCDD);
        step(1'b0, U_LDR, 32'd10, 32'h0);
        check("nop_ldr10", data_out, 32'h12345678);
        step(1'b0, U_LDR, 32'd7, 32'h0);
        check("nop_ldr7", data_out, 32'h0);

        // Aliasing, then reset overriding a store.
        step(1'b0, U_STR, 32'h0000_0021, 32'h55);
        step(1'b0, U_LDR, 32'd1, 32'h0);
        check("alias_ldr1", data_out, 32'h55);
        step(1'b1, U_STR, 32'd2, 32'h77);
        check("midreset_out", data_out, 32'h0);
        step(1'b0, U_LDR, 32'd2, 32'h0);
        check("midreset_ldr2", data_out, 32'h0);
        step(1'b0, U_LDR, 32'd1, 32'h0);
        check("midreset_ldr1", data_out, 32'h0);

        // Byte micro-ops: active with the feature, plain no-ops without it.
        step(1'b0, U_STR, 32'd0, 32'h11223344);
        check("b_str0", data_out, 32'h11223344);
`ifdef DCACHE_BYTE_EN
        step(1'b0, U_STRB, 32'd2, 32'h000000AA);
        check("b_strb_fwd", data_out, 32'h11AA3344);
        step(1'b0, U_LDR, 32'd0, 32'h0);
        check("b_ldr0", data_out, 32'h11AA3344);
        step(1'b0, U_LDRB, 32'd3, 32'h0);
        check("b_ldrb3", data_out, 32'h00000011);
`else
        step(1'b0, U_STRB, 32'd2, 32'h000000AA);
        check("b_strb_nop", data_out, 32'h11223344);
        step(1'b0, U_LDR, 32'd2, 32'h0);
        check("b_ldr2_untouched", data_out, 32'h0);
        step(1'b0, U_LDRB, 32'd0, 32'h0);
        check("b_ldrb_nop", data_out, 32'h0);
        step(1'b0, U_LDR, 32'd0, 32'h0);
        check("b_ldr0", data_out, 32'h11223344);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: ru = U_STR;
                3, 4, 5: ru = U_LDR;
                6:       ru = U_STRB;
                7:       ru = U_LDRB;
                default: ru = 5'($urandom);
            endcase
            ra = $urandom;
            rd = $urandom;
            rr = ($urandom_range(0, 49) == 0);
            step_check($sformatf("rand%0d_u%02h_a%08h", n, ru, ra), rr, ru, ra, rd);
        end

        // Final sweep of every word.
        for (int i = 0; i < DEPTH; i++) begin
            step_check($sformatf("sweep%0d", i), 1'b0, U_LDR, 32'(i), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
